// File: rtl/hf_blck_pkg.sv
// Shared types and widths for the hyperfabric block mover and its helpers.
package hf_blck_pkg;

   localparam int BLCK_ADDR_W    = 12;
   localparam int BLCK_CNT_W     = 6;
   localparam int BUF_ADDR_W     = BLCK_ADDR_W + 1;
   localparam int WORD_W         = 16;
   localparam int TIMEOUT_CYCLES = 255;

   localparam logic DIR_TO_DRAM   = 1'b0;
   localparam logic DIR_FROM_DRAM = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BRD,
      ST_BWAIT,
      ST_MREQ,
      ST_BWR,
      ST_DONE
   } mover_state_e;

   // Word address inside the selected bank; the 12-bit offset wraps modulo 4096.
   function automatic logic [BUF_ADDR_W-1:0] buf_word_addr(
      input logic                  bank,
      input logic [BLCK_ADDR_W-1:0] start,
      input logic [BLCK_CNT_W-1:0]  idx
   );
      logic [BLCK_ADDR_W-1:0] ofs;
      ofs = start + {{(BLCK_ADDR_W-BLCK_CNT_W){1'b0}}, idx};
      return {bank, ofs};
   endfunction

endpackage

// File: rtl/hf_block_mover_if.sv
// Controller command, memory word port and section buffer signals of the block mover.
interface hf_block_mover_if;
   import hf_blck_pkg::*;

   logic                   BLCK_ISSUE;
   logic [BLCK_ADDR_W-1:0] BLCK_START;
   logic [BLCK_CNT_W-1:0]  BLCK_COUNT_REQ;
   logic [1:0]             BLCK_SECTION;
   logic                   BLCK_ABORT;
   logic                   BLCK_WORKING;
   logic [BLCK_CNT_W-1:0]  BLCK_COUNT_SENT;
   logic                   BLCK_IRQ;
   logic                   BLCK_ABRUPT_STOP;
   logic                   BLCK_FRDRAM_DEVERR;

   logic                   MEM_REQ;
   logic                   MEM_WE;
   logic [BLCK_CNT_W-1:0]  MEM_ADDR;
   logic [WORD_W-1:0]      MEM_WDATA;
   logic [WORD_W-1:0]      MEM_RDATA;
   logic                   MEM_ACK;
   logic                   MEM_ERR;

   logic [BUF_ADDR_W-1:0]  BUF_ADDR;
   logic                   BUF_RE;
   logic                   BUF_WE;
   logic [WORD_W-1:0]      BUF_RDATA;
   logic [WORD_W-1:0]      BUF_WDATA;

   modport master (
      output BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, BLCK_ABORT,
      input  BLCK_WORKING, BLCK_COUNT_SENT, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR,
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      output MEM_RDATA, MEM_ACK, MEM_ERR,
      input  BUF_ADDR, BUF_RE, BUF_WE, BUF_WDATA,
      output BUF_RDATA
   );

   modport slave (
      input  BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, BLCK_ABORT,
      output BLCK_WORKING, BLCK_COUNT_SENT, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR,
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      input  MEM_RDATA, MEM_ACK, MEM_ERR,
      output BUF_ADDR, BUF_RE, BUF_WE, BUF_WDATA,
      input  BUF_RDATA
   );

endinterface

// File: rtl/hf_toggle_edge.sv
// Toggle-to-pulse detector; also used for the MCU refresh strobe.
// The history flop tracks the line even in reset so no false edge follows reset release.
module hf_toggle_edge (
   input  logic CLK,
   input  logic toggle_i,
   output logic pulse_o
);

   logic prev_q;

   always_ff @(posedge CLK) begin
      prev_q <= toggle_i;
   end

   assign pulse_o = toggle_i ^ prev_q;

endmodule

// File: rtl/hf_block_mover.sv
// Block mover: moves up to 63 words between the section buffer and the DRAM word port.
// Optional MEM_ACK watchdog built when HF_BLCK_MOVER_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | waiting for an issue toggle
//   BRD   | buffer read issued for word i
//   BWAIT | buffer data returning, latched as write data
//   MREQ  | memory request outstanding
//   BWR   | fetched word written into the buffer
//   DONE  | one-cycle completion pulse, then IDLE
module hf_block_mover
   import hf_blck_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   hf_block_mover_if.slave bus
);

   mover_state_e           state_q;
   logic [BLCK_ADDR_W-1:0] start_q;
   logic [BLCK_CNT_W-1:0]  count_q;
   logic                   dir_q;
   logic                   bank_q;
   logic [BLCK_CNT_W-1:0]  idx_q;
   logic [BLCK_CNT_W-1:0]  idx_d;
   logic [BLCK_CNT_W-1:0]  sent_q;
   logic                   working_q;
   logic                   irq_q;
   logic                   abrupt_q;
   logic                   deverr_q;
   logic                   mem_req_q;
   logic                   mem_we_q;
   logic [WORD_W-1:0]      mem_wdata_q;
   logic [BUF_ADDR_W-1:0]  buf_addr_q;
   logic                   buf_re_q;
   logic                   buf_we_q;
   logic [WORD_W-1:0]      buf_wdata_q;
   logic                   issue_pulse;
   logic                   timeout;

   hf_toggle_edge u_issue_edge (
      .CLK      (CLK),
      .toggle_i (bus.BLCK_ISSUE),
      .pulse_o  (issue_pulse)
   );

`ifdef HF_BLCK_MOVER_TIMEOUT_EN
   logic [7:0] wd_q;

   // Reloaded outside MREQ and on every ACK, so each word gets the full window.
   always_ff @(posedge CLK) begin
      if (!RST || state_q != ST_MREQ || bus.MEM_ACK) begin
         wd_q <= 8'(TIMEOUT_CYCLES - 1);
      end else if (wd_q != 8'd0) begin
         wd_q <= wd_q - 8'd1;
      end
   end

   assign timeout = (state_q == ST_MREQ) && (wd_q == 8'd0);
`else
   assign timeout = 1'b0;
`endif

   assign idx_d = idx_q + 1'b1;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         start_q     <= '0;
         count_q     <= '0;
         dir_q       <= 1'b0;
         bank_q      <= 1'b0;
         idx_q       <= '0;
         sent_q      <= '0;
         working_q   <= 1'b0;
         irq_q       <= 1'b0;
         abrupt_q    <= 1'b0;
         deverr_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         buf_addr_q  <= '0;
         buf_re_q    <= 1'b0;
         buf_we_q    <= 1'b0;
         buf_wdata_q <= '0;
      end else begin
         buf_re_q <= 1'b0;
         buf_we_q <= 1'b0;
         irq_q    <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (issue_pulse) begin
                  start_q   <= bus.BLCK_START;
                  count_q   <= bus.BLCK_COUNT_REQ;
                  dir_q     <= bus.BLCK_SECTION[0];
                  bank_q    <= bus.BLCK_SECTION[1];
                  idx_q     <= '0;
                  sent_q    <= '0;
                  abrupt_q  <= 1'b0;
                  deverr_q  <= 1'b0;
                  working_q <= 1'b1;
                  if (bus.BLCK_COUNT_REQ == '0) begin
                     state_q <= ST_DONE;
                     irq_q   <= 1'b1;
                  end else if (bus.BLCK_SECTION[0] == DIR_TO_DRAM) begin
                     state_q    <= ST_BRD;
                     buf_re_q   <= 1'b1;
                     buf_addr_q <= buf_word_addr(bus.BLCK_SECTION[1], bus.BLCK_START, '0);
                  end else begin
                     state_q   <= ST_MREQ;
                     mem_req_q <= 1'b1;
                     mem_we_q  <= 1'b0;
                  end
               end
            end
            ST_BRD: begin
               if (bus.BLCK_ABORT) begin
                  abrupt_q <= 1'b1;
                  state_q  <= ST_DONE;
                  irq_q    <= 1'b1;
               end else begin
                  state_q <= ST_BWAIT;
               end
            end
            ST_BWAIT: begin
               mem_wdata_q <= bus.BUF_RDATA;
               if (bus.BLCK_ABORT) begin
                  abrupt_q <= 1'b1;
                  state_q  <= ST_DONE;
                  irq_q    <= 1'b1;
               end else begin
                  state_q   <= ST_MREQ;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= 1'b1;
               end
            end
            ST_MREQ: begin
               if (bus.MEM_ACK) begin
                  mem_req_q <= 1'b0;
                  if (bus.MEM_ERR) begin
                     abrupt_q <= 1'b1;
                     if (dir_q == DIR_FROM_DRAM) deverr_q <= 1'b1;
                     state_q  <= ST_DONE;
                     irq_q    <= 1'b1;
                  end else begin
                     // An abort coinciding with ACK still lets this word count.
                     sent_q <= sent_q + 1'b1;
                     idx_q  <= idx_d;
                     if (bus.BLCK_ABORT) abrupt_q <= 1'b1;
                     if (dir_q == DIR_FROM_DRAM) begin
                        state_q     <= ST_BWR;
                        buf_we_q    <= 1'b1;
                        buf_wdata_q <= bus.MEM_RDATA;
                        buf_addr_q  <= buf_word_addr(bank_q, start_q, idx_q);
                     end else if (idx_d == count_q || bus.BLCK_ABORT) begin
                        state_q <= ST_DONE;
                        irq_q   <= 1'b1;
                     end else begin
                        state_q    <= ST_BRD;
                        buf_re_q   <= 1'b1;
                        buf_addr_q <= buf_word_addr(bank_q, start_q, idx_d);
                     end
                  end
               end else if (bus.BLCK_ABORT || timeout) begin
                  mem_req_q <= 1'b0;
                  abrupt_q  <= 1'b1;
                  state_q   <= ST_DONE;
                  irq_q     <= 1'b1;
               end
            end
            ST_BWR: begin
               if (bus.BLCK_ABORT) abrupt_q <= 1'b1;
               if (bus.BLCK_ABORT || abrupt_q || idx_q == count_q) begin
                  state_q <= ST_DONE;
                  irq_q   <= 1'b1;
               end else begin
                  state_q   <= ST_MREQ;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q   <= ST_IDLE;
               working_q <= 1'b0;
            end
            default: begin
               state_q   <= ST_IDLE;
               working_q <= 1'b0;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.BLCK_WORKING       = working_q;
   assign bus.BLCK_COUNT_SENT    = sent_q;
   assign bus.BLCK_IRQ           = irq_q;
   assign bus.BLCK_ABRUPT_STOP   = abrupt_q;
   assign bus.BLCK_FRDRAM_DEVERR = deverr_q;
   // Request is gated by reset so it drops without waiting for a clock edge.
   assign bus.MEM_REQ            = mem_req_q & RST;
   assign bus.MEM_WE             = mem_we_q;
   assign bus.MEM_ADDR           = idx_q;
   assign bus.MEM_WDATA          = mem_wdata_q;
   assign bus.BUF_ADDR           = buf_addr_q;
   assign bus.BUF_RE             = buf_re_q;
   assign bus.BUF_WE             = buf_we_q;
   assign bus.BUF_WDATA          = buf_wdata_q;

endmodule
